// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
// Alignment helpers are only referenced when DM_ALIGN_CHECK_EN is defined.
package dm_pkg;

  localparam int DM_DATA_W = 32;
  localparam int DM_BE_W   = 4;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dm_state_e;

  // Byte-enable shapes a naturally aligned byte, halfword or word access can take
  localparam int DM_NUM_LEGAL_BE = 7;
  localparam logic [DM_BE_W-1:0] DM_LEGAL_BE [DM_NUM_LEGAL_BE] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic [1:0] lowest_lane(input logic [DM_BE_W-1:0] be);
    lowest_lane = 2'd0;
    for (int i = DM_BE_W - 1; i >= 0; i--) begin
      if (be[i]) lowest_lane = 2'(i);
    end
  endfunction

  function automatic logic be_is_legal(input logic [DM_BE_W-1:0] be);
    be_is_legal = 1'b0;
    for (int i = 0; i < DM_NUM_LEGAL_BE; i++) begin
      if (be == DM_LEGAL_BE[i]) be_is_legal = 1'b1;
    end
  endfunction

endpackage

// File: rtl/dm_be_merge.sv
// Byte-lane merge: lanes with be set take the new data, the rest keep the old word.
module dm_be_merge
  import dm_pkg::*;
(
  input  logic [DM_DATA_W-1:0] old_word,
  input  logic [DM_DATA_W-1:0] wdata,
  input  logic [DM_BE_W-1:0]   be,
  output logic [DM_DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DM_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a held response.
// Optional DM_ALIGN_CHECK_EN adds byte-enable shape and address alignment checking.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Once raised,
// rsp_valid, rsp_rdata and rsp_err stay stable until that transfer.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [DM_BE_W-1:0]   req_be,
  input  logic [31:0]          req_addr,
  input  logic [DM_DATA_W-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DM_DATA_W-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  dm_state_e state;
  dm_state_e next_state;
  logic      started;
  logic [3:0] cnt;
  logic      commit_en;
  logic      accept;

  logic                 lat_we;
  logic [DM_BE_W-1:0]   lat_be;
  logic [IDX_W-1:0]     lat_idx;
  logic [DM_DATA_W-1:0] lat_wdata;
  logic                 lat_err;

  logic                 req_err;
  logic                 in_range;
  logic                 c_we;
  logic [DM_BE_W-1:0]   c_be;
  logic [IDX_W-1:0]     c_idx;
  logic [DM_DATA_W-1:0] c_wdata;
  logic                 c_err;
  logic [DM_DATA_W-1:0] old_word;
  logic [DM_DATA_W-1:0] merged;

  logic [DM_DATA_W-1:0] mem [DEPTH_WORDS];

  assign req_ready = started && (state == DM_IDLE);
  assign rsp_valid = (state == DM_RESP);
  assign accept    = req_valid && req_ready;
  assign in_range  = (req_addr[31:2] < 30'(DEPTH_WORDS));

`ifdef DM_ALIGN_CHECK_EN
  assign req_err = !in_range || !be_is_legal(req_be) ||
                   (req_addr[1:0] != lowest_lane(req_be));
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];
  assign req_err = !in_range;
`endif

  // With zero wait states the commit uses the live request on the acceptance edge
  assign c_we    = (state == DM_IDLE) ? req_we                 : lat_we;
  assign c_be    = (state == DM_IDLE) ? req_be                 : lat_be;
  assign c_idx   = (state == DM_IDLE) ? req_addr[IDX_W+1:2]    : lat_idx;
  assign c_wdata = (state == DM_IDLE) ? req_wdata              : lat_wdata;
  assign c_err   = (state == DM_IDLE) ? req_err                : lat_err;

  assign old_word = mem[c_idx];

  dm_be_merge u_merge (
    .old_word (old_word),
    .wdata    (c_wdata),
    .be       (c_be),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= DM_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    commit_en  = 1'b0;
    case (state)
      DM_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            commit_en  = 1'b1;
            next_state = DM_RESP;
          end else begin
            next_state = DM_WAIT;
          end
        end
      end
      DM_WAIT: begin
        if (cnt <= 4'd1) begin
          commit_en  = 1'b1;
          next_state = DM_RESP;
        end
      end
      DM_RESP: begin
        if (rsp_ready) next_state = DM_IDLE;
      end
      default: next_state = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      started   <= 1'b0;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_err   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        lat_we    <= req_we;
        lat_be    <= req_be;
        lat_idx   <= req_addr[IDX_W+1:2];
        lat_wdata <= req_wdata;
        lat_err   <= req_err;
        cnt       <= WAIT_LOAD;
      end else if (state == DM_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit_en) begin
        rsp_rdata <= (c_we || c_err) ? '0 : old_word;
        rsp_err   <= c_err;
      end else if ((state == DM_RESP) && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Array contents survive reset; commit_en is gated by the reset-cleared FSM
  always_ff @(posedge clk) begin
    if (commit_en && c_we && !c_err) mem[c_idx] <= merged;
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
// Honours DM_ALIGN_CHECK_EN when the build defines it.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dm_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  // Starts at a negedge; returns at the negedge where rsp_valid is first seen.
  task automatic send_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
    int n;
    req_we = we; req_be = be; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); lat = 1;
    @(negedge clk); req_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic err);
    send_req(we, be, addr, wdata, lat);
    rdata = rsp_rdata; err = rsp_err;
    consume();
  endtask

  task automatic test_reset();
    clr = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h required all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    clr = 1'b1; #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++; $display("FAIL ready_before_edge: req_ready=%b required 0", req_ready);
    end
    @(posedge clk); @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL ready_after_edge: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_full_word();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, lat, rd, er);
    tests_run++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL store_full: lat=%0d err=%b rdata=%h required 3/0/00000000", lat, er, rd);
    end
    do_req(1'b0, 4'b1111, 32'h10, 32'h0, lat, rd, er);
    tests_run++;
    if (lat !== 3) begin
      tests_failed++; $display("FAIL load_latency: got %0d required 3", lat);
    end
    tests_run++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      tests_failed++; $display("FAIL load_full: rdata=%h err=%b required deadbeef/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$]; int bad_rsp; int n_rsp;
    bad_rsp = 0; n_rsp = 0;
    req_we = 1'b0; req_be = 4'b1111; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) acc_cyc.push_back(c);
      if (rsp_valid) begin
        n_rsp++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) bad_rsp++;
      end
      @(posedge clk); @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    tests_run++;
    if (acc_cyc.size() !== 3) begin
      tests_failed++; $display("FAIL b2b_accepts: got %0d required 3", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] !== 4 || acc_cyc[2] - acc_cyc[1] !== 4) begin
      tests_failed++;
      $display("FAIL b2b_spacing: accepts at %0d,%0d,%0d required spacing 4",
               acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    end
    tests_run++;
    if (n_rsp !== 3 || bad_rsp !== 0) begin
      tests_failed++;
      $display("FAIL b2b_responses: count=%0d bad=%0d required 3/0", n_rsp, bad_rsp);
    end
  endtask

  task automatic test_byte_lane();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 4'b1111, 32'h10, 32'h11223344, lat, rd, er);
    do_req(1'b1, 4'b0100, 32'h12, 32'h00AA0000, lat, rd, er);
    tests_run++;
    if (er !== 1'b0) begin
      tests_failed++; $display("FAIL lane_store_err: err=%b required 0", er);
    end
    do_req(1'b0, 4'b1111, 32'h10, 32'h0, lat, rd, er);
    tests_run++;
    if (rd !== 32'h11AA3344) begin
      tests_failed++; $display("FAIL lane_merge: rdata=%h required 11aa3344", rd);
    end
  endtask

  task automatic test_stall();
    int lat; int good; logic [31:0] rd; logic er;
    do_req(1'b1, 4'b1111, 32'h30, 32'h55555555, lat, rd, er);
    send_req(1'b1, 4'b0001, 32'h30, 32'h000000C3, lat);
    good = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid === 1'b1 && req_ready === 1'b0 && rsp_rdata === 32'h0 && rsp_err === 1'b0)
        good++;
      @(posedge clk); @(negedge clk);
    end
    tests_run++;
    if (good !== 10) begin
      tests_failed++; $display("FAIL stall_hold: good_cycles=%0d required 10", good);
    end
    consume();
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: ready=%b valid=%b required 1/0", req_ready, rsp_valid);
    end
    do_req(1'b0, 4'b1111, 32'h30, 32'h0, lat, rd, er);
    tests_run++;
    if (rd !== 32'h555555C3) begin
      tests_failed++; $display("FAIL stall_word: rdata=%h required 555555c3", rd);
    end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 4'b1111, 32'h0, 32'hCAFEF00D, lat, rd, er);
    do_req(1'b0, 4'b1111, 32'h1000, 32'h0, lat, rd, er);
    tests_run++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
      tests_failed++;
      $display("FAIL range_load: err=%b rdata=%h lat=%0d required 1/00000000/3", er, rd, lat);
    end
    do_req(1'b1, 4'b1111, 32'h1000, 32'h12345678, lat, rd, er);
    tests_run++;
    if (er !== 1'b1) begin
      tests_failed++; $display("FAIL range_store_err: err=%b required 1", er);
    end
    do_req(1'b0, 4'b1111, 32'h0, 32'h0, lat, rd, er);
    tests_run++;
    if (rd !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL range_no_write: word0=%h required cafef00d", rd);
    end
  endtask

  task automatic test_clr_mid();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 4'b1111, 32'h20, 32'h0, lat, rd, er);
    req_we = 1'b1; req_be = 4'b1111; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    #1 clr = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL clr_wait_outputs: ready=%b valid=%b err=%b rdata=%h required all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    do_req(1'b0, 4'b1111, 32'h20, 32'h0, lat, rd, er);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      tests_failed++; $display("FAIL clr_discard: rdata=%h err=%b required 00000000/0", rd, er);
    end
    send_req(1'b0, 4'b1111, 32'h10, 32'h0, lat);
    tests_run++;
    if (rsp_rdata !== 32'h11AA3344 || rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_resp_before: valid=%b rdata=%h required 1/11aa3344", rsp_valid, rsp_rdata);
    end
    #2 clr = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL clr_resp_outputs: ready=%b valid=%b err=%b rdata=%h required all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(posedge clk); @(negedge clk);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    do_req(1'b0, 4'b1111, 32'h10, 32'h0, lat, rd, er);
    tests_run++;
    if (rd !== 32'h11AA3344 || lat !== 3) begin
      tests_failed++;
      $display("FAIL clr_recover: rdata=%h lat=%0d required 11aa3344/3", rd, lat);
    end
  endtask

  task automatic test_align();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 4'b0011, 32'h01, 32'h0000BEEF, lat, rd, er);
`ifdef DM_ALIGN_CHECK_EN
    tests_run++;
    if (er !== 1'b1) begin
      tests_failed++; $display("FAIL align_err: err=%b required 1", er);
    end
    do_req(1'b0, 4'b1111, 32'h0, 32'h0, lat, rd, er);
    tests_run++;
    if (rd !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL align_no_write: word0=%h required cafef00d", rd);
    end
    do_req(1'b1, 4'b1100, 32'h02, 32'h12340000, lat, rd, er);
    do_req(1'b0, 4'b1111, 32'h0, 32'h0, lat, rd, er);
    tests_run++;
    if (rd !== 32'h1234F00D || er !== 1'b0) begin
      tests_failed++; $display("FAIL align_legal: word0=%h err=%b required 1234f00d/0", rd, er);
    end
`else
    tests_run++;
    if (er !== 1'b0) begin
      tests_failed++; $display("FAIL align_ignored_err: err=%b required 0", er);
    end
    do_req(1'b0, 4'b1111, 32'h0, 32'h0, lat, rd, er);
    tests_run++;
    if (rd !== 32'hCAFEBEEF) begin
      tests_failed++; $display("FAIL align_ignored_write: word0=%h required cafebeef", rd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_byte_lane();
    test_stall();
    test_range();
    test_clr_mid();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
